// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//
// Instruction source that sits directly upstream of the pipelined ARM core and
// drives its Instruction input. A loader pushes 32-bit words into a FIFO. The
// block issues them one at a time. After each issued word it inserts NOP_GAP
// NOP_WORD cycles, so the core sees hazard-free spacing without forwarding.
//
// Ports
//   clk          in   1        core clock, rising edge
//   reset        in   1        synchronous, active-low reset
//   load_instr   in   32       word to enqueue
//   load_valid   in   1        loader has a word
//   load_ready   out  1        FIFO can accept (push = load_valid & load_ready)
//   stall        in   1        freeze the issue side; pushes are still accepted
//   flush        in   1        discard the queue and any pending padding
//   Instruction  out  32       registered word to the core
//   issue_valid  out  1        Instruction holds a real queued word
//   pad_active   out  1        Instruction holds a padding NOP
//   fifo_count   out  CW       number of queued words
//   issued_count out  16       real words issued since reset/flush (wraps)
// -----------------------------------------------------------------------------
module instr_issue_queue #(
  parameter int          DEPTH    = 16,
  parameter int          NOP_GAP  = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                load_instr,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [31:0]                Instruction,
  output logic                       issue_valid,
  output logic                       pad_active,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [15:0]                issued_count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  // Keep the pad counter at least one bit wide so a NOP_GAP=0 build still elaborates.
  localparam int PCW = (NOP_GAP > 0) ? $clog2(NOP_GAP + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  // FIFO storage: no reset, so it maps onto RAM. The read is registered
  // through instr_q, which is the output register toward the core.
  logic [31:0]    mem_q [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [0:0]     state_q, state_d;
  logic [PCW-1:0] pad_cnt_q, pad_cnt_d;
  logic [31:0]    instr_q, instr_d;
  logic           issue_valid_q, issue_valid_d;
  logic           pad_active_q, pad_active_d;
  logic [15:0]    issued_q, issued_d;

  logic           push;
  logic           pop;
  logic [31:0]    head;

  // Ready comes only from the registered count. A simultaneous pop does not
  // open a slot in the same cycle.
  assign load_ready = (count_q < CW'(DEPTH));
  // A word presented during a flush is dropped along with the queue.
  assign push = load_valid && load_ready && !flush;
  assign pop  = !flush && !stall && (state_q == ST_IDLE) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    pad_cnt_d     = pad_cnt_q;
    instr_d       = instr_q;
    issue_valid_d = issue_valid_q;
    pad_active_d  = pad_active_q;
    issued_d      = issued_q;

    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      state_d       = ST_IDLE;
      pad_cnt_d     = '0;
      instr_d       = NOP_WORD;
      issue_valid_d = 1'b0;
      pad_active_d  = 1'b0;
      issued_d      = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // With stall asserted the whole issue side holds its previous values.
      if (!stall) begin
        case (state_q)
          ST_IDLE: begin
            pad_active_d = 1'b0;
            if (pop) begin
              instr_d       = head;
              issue_valid_d = 1'b1;
              issued_d      = issued_q + 16'd1;
              if (NOP_GAP > 0) begin
                pad_cnt_d = PCW'(NOP_GAP);
                state_d   = ST_PAD;
              end
            end else begin
              instr_d       = NOP_WORD;
              issue_valid_d = 1'b0;
            end
          end
          ST_PAD: begin
            instr_d       = NOP_WORD;
            issue_valid_d = 1'b0;
            pad_active_d  = 1'b1;
            pad_cnt_d     = pad_cnt_q - 1'b1;
            // The last padding cycle returns to IDLE so the next word issues
            // on the following edge. This gives a spacing of NOP_GAP+1.
            if (pad_cnt_q <= PCW'(1)) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= load_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      pad_cnt_q     <= '0;
      instr_q       <= NOP_WORD;
      issue_valid_q <= 1'b0;
      pad_active_q  <= 1'b0;
      issued_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      pad_cnt_q     <= pad_cnt_d;
      instr_q       <= instr_d;
      issue_valid_q <= issue_valid_d;
      pad_active_q  <= pad_active_d;
      issued_q      <= issued_d;
    end
  end

  assign Instruction  = instr_q;
  assign issue_valid  = issue_valid_q;
  assign pad_active   = pad_active_q;
  assign fifo_count   = count_q;
  assign issued_count = issued_q;

endmodule
